ascii_uart_tx: RTL
==================

// Module: ascii_uart_tx
// PURPOSE
//  Downstream consumer of the 8-bit ASCII character stream produced by the chip's
//  message generator. Buffers characters in a small FIFO and serialises them as
//  8N1 UART frames on a single pin, so the message can be read on a terminal.
//  Sits between the character generator output and a top-level output pin.
// PARAMETERS
//  CLKS_PER_BIT  16  clk cycles per UART bit; legal range >= 2
//  FIFO_DEPTH    4   character FIFO entries; power of 2, >= 2
//  DROP_NUL      1   1: accepted bytes equal to 8'h00 are discarded (never queued)
// PORTS
//  clk         in   1   single clock, all logic on posedge
//  reset       in   1   synchronous, active-high
//  char_in     in   8   ASCII character from upstream generator
//  char_valid  in   1   char_in is valid this cycle
//  char_ready  out  1   FIFO can accept; transfer = char_valid & char_ready at posedge
//  en          in   1   1: may start new frames; 0: hold after current frame
//  tx          out  1   UART serial output, idle high, registered
//  busy        out  1   1 while a frame is in progress (state != IDLE)
//  fifo_level  out  $clog2(FIFO_DEPTH)+1  entries currently queued
// BEHAVIOUR
//  Reset (sync): tx=1, busy=0, fifo_level=0, char_ready=1, FSM=IDLE, FIFO flushed,
//   baud and bit counters cleared. Reset mid-frame aborts: tx=1 on the next cycle.
//  FIFO: char_ready = !full (combinational from registered level, not from pop).
//   Push when char_valid&char_ready (and !(DROP_NUL && char_in==0)).
//   No write-through: byte pushed at edge k is poppable at edge k+1.
//   Push and pop on the same edge: level unchanged, both take effect.
//   Full: char_ready=0, char_valid ignored, no overwrite. Pointers wrap mod FIFO_DEPTH.
//  FSM states IDLE, START, DATA, STOP:
//   IDLE : tx=1. If level!=0 && en at an edge: pop head into shift reg, -> START.
//   START: tx=0 for CLKS_PER_BIT cycles, -> DATA with bit index 0.
//   DATA : tx=shift[0] per bit, LSB first; shift right every CLKS_PER_BIT;
//          after 8th bit -> STOP.
//   STOP : tx=1 for CLKS_PER_BIT cycles; at end, if level!=0 && en, pop and
//          -> START directly (no idle gap), else -> IDLE.
//  Frame = 10*CLKS_PER_BIT cycles. Latency: byte accepted into empty FIFO at edge k,
//   popped at edge k+1, tx=0 from cycle after edge k+1 (2 cycles).
//  en is sampled only at pop decisions; deasserting en mid-frame never truncates
//   the current frame; queued bytes stay queued.
//  Baud counter counts 0..CLKS_PER_BIT-1, cleared on every state change.
//  busy=1 from the cycle tx first goes low through the last STOP cycle.
//  No bytes are lost or reordered except by reset or DROP_NUL.
// TESTING (CLKS_PER_BIT=4, FIFO_DEPTH=4 unless stated)
//  1. Push 8'h47 ('G') into empty FIFO -> tx=0 from 2 cycles after acceptance for 4
//     cycles, then 1,1,1,0,0,0,1,0 (4 cycles each), stop=1; busy high 40 cycles.
//  2. Stream "Guatemala" (9 bytes, valid held, honour ready) -> char_ready drops
//     while level==4; 9 frames back-to-back, 360 cycles, receiver model decodes
//     exact string in order.
//  3. DROP_NUL=1, push 8'h00 -> accepted, fifo_level stays 0, tx stays 1;
//     DROP_NUL=0 -> one frame with 8 zero data bits.
//  4. en=0, push 5 bytes -> 4 accepted, 5th stalls, level=4, tx=1; raise en ->
//     first start bit within 1 cycle, 5th byte accepted after first pop.
//  5. Drop en during DATA of frame 1 with 2 queued -> frame 1 completes, tx idles,
//     level=2; restore en -> remaining frames sent.
//  6. Assert reset during a DATA bit with level=3 -> next cycle tx=1, busy=0,
//     fifo_level=0, char_ready=1; no further frames.

Source files
------------

// File: rtl/ascii_uart_tx.sv
// Character FIFO feeding an 8N1 UART serialiser. tx is registered and idles high.
// Characters are popped only at the decision points in IDLE and at the end of STOP.
module ascii_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter bit DROP_NUL     = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    char_in,
  input  logic                          char_valid,
  output logic                          char_ready,
  input  logic                          en,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [LW-1:0] level_q, level_d;
  state_e        state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tx_q;
  logic          push, pop, baud_end;

  assign baud_end   = (baud_q == BW'(CLKS_PER_BIT - 1));
  assign char_ready = (level_q != LW'(FIFO_DEPTH));
  assign push       = char_valid && char_ready && !(DROP_NUL && (char_in == 8'h00));
  // Pop only reads entries written on an earlier edge, so there is no write-through path.
  assign pop        = en && (level_q != '0) &&
                      ((state_q == IDLE) || ((state_q == STOP) && baud_end));

  always_comb begin
    level_d = level_q;
    if (push && !pop)      level_d = level_q + LW'(1);
    else if (pop && !push) level_d = level_q - LW'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= char_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + PW'(1);
      if (pop)  rd_q <= rd_q + PW'(1);
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          baud_q <= '0;
          tx_q   <= 1'b1;
          if (pop) begin
            shift_q <= mem_q[rd_q];
            state_q <= START;
            tx_q    <= 1'b0;
          end
        end
        START: begin
          if (baud_end) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= DATA;
            tx_q    <= shift_q[0];
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              shift_q <= shift_q >> 1;
              bit_q   <= bit_q + 3'd1;
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        STOP: begin
          if (baud_end) begin
            baud_q <= '0;
            // Chain straight into the next start bit when more data is queued.
            if (pop) begin
              shift_q <= mem_q[rd_q];
              state_q <= START;
              tx_q    <= 1'b0;
            end else begin
              state_q <= IDLE;
              tx_q    <= 1'b1;
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign tx         = tx_q;
  assign busy       = (state_q != IDLE);
  assign fifo_level = level_q;
endmodule
